multi_channel_debouncer: RTL and testbench

Parametrised N-channel debouncer for push-buttons and switches on the board I/O.
- Per channel: configurable-depth synchroniser, then a stability counter that requires a new level to persist STABLE_CYCLES consecutive cycles before the output changes.
- Adds one-cycle rise/fall pulses and a per-channel settling flag; the single fixed 2-flop compare scheme has none of these.
- Sits between raw pad inputs and control FSMs that consume clean levels or edge events.

---
 rtl/multi_channel_debouncer_pkg.sv | 20 ++
 rtl/multi_channel_debouncer_debounce_cell.sv | 71 +++++++
 rtl/multi_channel_debouncer.sv | 35 +++
 tb/tb_multi_channel_debouncer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_debouncer_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
// Provides the counter width derivation and the default reset level.
package multi_channel_debouncer_pkg;

  localparam logic DEFAULT_RESET_LEVEL = 1'b0;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Counter width that holds STABLE_CYCLES-1 without wrapping.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/multi_channel_debouncer_debounce_cell.sv
// One debounce channel: synchroniser, stability counter, level register,
// one-cycle rise/fall pulses and a settling flag.
module debounce_cell
  import multi_channel_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RESET_LEVEL   = DEFAULT_RESET_LEVEL
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic settling
);

  localparam int unsigned      CNT_W   = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_settling;
  logic                   w_s;
  logic                   w_diff;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = (w_s != r_level);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
  end

  // Accept a new level only after it has differed for STABLE_CYCLES edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_level    <= RESET_LEVEL;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_settling <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_diff) begin
        r_cnt      <= '0;
        r_settling <= 1'b0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt      <= '0;
        r_settling <= 1'b0;
        r_level    <= w_s;
        r_rise     <= w_s;
        r_fall     <= ~w_s;
      end else begin
        r_cnt      <= r_cnt + CNT_W'(1);
        r_settling <= 1'b1;
      end
    end
  end

  assign level_out  = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign settling   = r_settling;

endmodule

// File: rtl/multi_channel_debouncer.sv
// N-channel debouncer: independent debounce_cell per input bit.
module multi_channel_debouncer
  import multi_channel_debouncer_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RESET_LEVEL   = DEFAULT_RESET_LEVEL
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] settling
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_cell #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_LEVEL  (RESET_LEVEL)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .async_in  (async_in[g]),
      .level_out (level_out[g]),
      .rise_pulse(rise_pulse[g]),
      .fall_pulse(fall_pulse[g]),
      .settling  (settling[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Bench: two debouncer instances (STABLE_CYCLES 4 and 16) against a
// sliding-window reference model, plus directed literal checks.
module tb_multi_channel_debouncer;

  localparam int NCH  = 6;
  localparam int SYNC = 2;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] din   = '0;
  logic [NCH-1:0] lvl, rise, fall, sett;

  int checks = 0;
  int errors = 0;

  multi_channel_debouncer #(
    .CHANNELS(4), .SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .async_in(din[3:0]),
    .level_out(lvl[3:0]), .rise_pulse(rise[3:0]),
    .fall_pulse(fall[3:0]), .settling(sett[3:0])
  );

  multi_channel_debouncer #(
    .CHANNELS(2), .SYNC_STAGES(2), .STABLE_CYCLES(16), .RESET_LEVEL(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .async_in(din[5:4]),
    .level_out(lvl[5:4]), .rise_pulse(rise[5:4]),
    .fall_pulse(fall[5:4]), .settling(sett[5:4])
  );

  always #5 clk = ~clk;

  // Reference model: input delay line, window of recent synchronised values.
  logic [NCH-1:0] h_in[$];
  logic [NCH-1:0] h_s[$];
  logic [NCH-1:0] m_lvl, m_rise, m_fall, m_set;

  function automatic int stab(input int ch);
    return (ch < 4) ? 4 : 16;
  endfunction

  task automatic model_reset();
    h_in = {};
    h_s  = {};
    repeat (SYNC) h_in.push_back('0);
    repeat (16) h_s.push_back('0);
    m_lvl  = '0;
    m_rise = '0;
    m_fall = '0;
    m_set  = '0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] s_vec;
    bit             all_diff;
    s_vec = h_in.pop_front();
    h_in.push_back(din);
    h_s.push_back(s_vec);
    void'(h_s.pop_front());
    for (int ch = 0; ch < NCH; ch++) begin
      all_diff = 1'b1;
      for (int k = 0; k < stab(ch); k++)
        if (h_s[h_s.size() - 1 - k][ch] == m_lvl[ch]) all_diff = 1'b0;
      m_rise[ch] = all_diff && s_vec[ch];
      m_fall[ch] = all_diff && !s_vec[ch];
      if (all_diff) m_lvl[ch] = s_vec[ch];
      m_set[ch] = (s_vec[ch] != m_lvl[ch]);
    end
  endtask

  task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge reset) model_reset();

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    if (!reset) model_step();
    #1;
    chk("level", lvl, m_lvl);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("settling", sett, m_set);
  end

  initial begin
    model_reset();
    edges(3);
    reset = 1'b0;

    // Idle after reset: nothing moves.
    edges(20);
    chk("s1_level", lvl, 6'b0);
    chk("s1_pulses", rise | fall | sett, 6'b0);

    // Step on ch0: settling after edges 3..5, level+rise after edge 6.
    din[0] = 1'b1;
    edges(2);
    chk("s2_settle_e2", {5'b0, sett[0]}, 6'd0);
    edges(1);
    chk("s2_settle_e3", {5'b0, sett[0]}, 6'd1);
    edges(2);
    chk("s2_settle_e5", {5'b0, sett[0]}, 6'd1);
    chk("s2_level_e5", {5'b0, lvl[0]}, 6'd0);
    edges(1);
    chk("s2_level_e6", {5'b0, lvl[0]}, 6'd1);
    chk("s2_rise_e6", {5'b0, rise[0]}, 6'd1);
    chk("s2_settle_e6", {5'b0, sett[0]}, 6'd0);
    edges(1);
    chk("s2_rise_e7", {5'b0, rise[0]}, 6'd0);

    // Glitch on ch1 of three cycles: rejected.
    din[1] = 1'b1;
    edges(3);
    din[1] = 1'b0;
    edges(10);
    chk("s3_level", {5'b0, lvl[1]}, 6'd0);
    chk("s3_settle", {5'b0, sett[1]}, 6'd0);

    // Simultaneous rise on ch2 and fall on ch3.
    din[3] = 1'b1;
    edges(8);
    chk("s4_preload", {2'b0, lvl[3:0]}, 6'b001001);
    din[2] = 1'b1;
    din[3] = 1'b0;
    edges(5);
    chk("s4_early", {2'b0, rise[3:0] | fall[3:0]}, 6'd0);
    edges(1);
    chk("s4_rise", {2'b0, rise[3:0]}, 6'b000100);
    chk("s4_fall", {2'b0, fall[3:0]}, 6'b001000);
    chk("s4_level", {2'b0, lvl[3:0]}, 6'b000101);
    edges(1);
    chk("s4_after", {2'b0, rise[3:0] | fall[3:0]}, 6'd0);

    // Reset in mid-count; full latency again after release.
    din[0] = 1'b0;
    edges(8);
    chk("s5_pre", {2'b0, lvl[3:0]}, 6'b000100);
    din[0] = 1'b1;
    edges(4);
    chk("s5_settle", {5'b0, sett[0]}, 6'd1);
    reset = 1'b1;
    #1;
    chk("s5_async_level", lvl, 6'd0);
    chk("s5_async_settle", sett, 6'd0);
    edges(2);
    reset = 1'b0;
    edges(5);
    chk("s5_no_early_rise", {2'b0, rise[3:0]}, 6'd0);
    edges(1);
    chk("s5_rise", {2'b0, rise[3:0]}, 6'b000101);

    // STABLE_CYCLES=16 channel: 15-cycle runs never accepted.
    for (int i = 0; i < 14; i++) begin
      din[4] = ~din[4];
      edges(15);
    end
    chk("s6_toggle_level", {5'b0, lvl[4]}, 6'd0);
    din[4] = 1'b0;
    edges(20);
    din[4] = 1'b1;
    edges(17);
    chk("s6_level_e17", {5'b0, lvl[4]}, 6'd0);
    edges(1);
    chk("s6_level_e18", {5'b0, lvl[4]}, 6'd1);
    chk("s6_rise_e18", {5'b0, rise[4]}, 6'd1);

    // Random toggling with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(0, 5) == 0) din[ch] = ~din[ch];
      for (int ch = 4; ch < NCH; ch++)
        if ($urandom_range(0, 19) == 0) din[ch] = ~din[ch];
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #1;
        chk("rand_async_reset", lvl | rise | fall | sett, 6'd0);
      end
    end
    reset = 1'b0;
    edges(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
